decoder_pipe: RTL and testbench

//  Parametrised registered 1-of-N decoder with valid/ready handshake on both sides.

---
 rtl/decoder_pipe_if.sv | 31 +++
 rtl/decoder_pipe.sv | 118 +++++++++++
 tb/tb_decoder_pipe.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/decoder_pipe_if.sv
// Handshake bundle for decoder_pipe: select in, decoded word out, oor counter.
// Latency: none (wires only).
// Backpressure: carries in_valid/in_ready and out_valid/out_ready pairs.
// Ports: en, in_valid, in_ready, in_sel, out_valid, out_ready, out_data,
//        out_oor, clr_count, oor_count. master = driver side, slave = decoder.
interface decoder_pipe_if #(
  parameter int SEL_W = 3,
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
);
  logic             en;
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_oor;
  logic             clr_count;
  logic [CNT_W-1:0] oor_count;

  modport master (
    output en, in_valid, in_sel, out_ready, clr_count,
    input  in_ready, out_valid, out_data, out_oor, oor_count
  );

  modport slave (
    input  en, in_valid, in_sel, out_ready, clr_count,
    output in_ready, out_valid, out_data, out_oor, oor_count
  );
endinterface

// File: rtl/decoder_pipe.sv
// Registered 1-of-N decoder (one-hot or one-cold) with out-of-range flag and counter.
// Latency: 1 cycle from accept to out_valid when empty; 1 entry/cycle sustained.
// Backpressure: output register plus one skid entry; in_ready drops only when both are held.
// Ports: clk, rst (sync, active-high), bus (decoder_pipe_if.slave): en gates
//        acceptance only, in_* select side, out_* decoded side, clr_count/oor_count.
module decoder_pipe #(
  parameter int SEL_W      = 3,
  parameter int OUT_W      = 8,
  parameter int ACTIVE_LOW = 1,
  parameter int CNT_W      = 16
) (
  input  logic           clk,
  input  logic           rst,
  decoder_pipe_if.slave  bus
);

  localparam logic [OUT_W-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  typedef struct packed {
    logic             oor;
    logic [OUT_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam entry_t IDLE_ENTRY = '{oor: 1'b0, data: INACTIVE};

  state_t           state;
  entry_t           oreg;
  entry_t           skid;
  logic             out_valid_q;
  logic [CNT_W-1:0] cnt;

  logic   accept;
  logic   drain;
  logic   inc;
  entry_t dec;

  // Selects past the last lane leave the word inactive and raise oor.
  function automatic entry_t decode(input logic [SEL_W-1:0] s);
    entry_t e;
    e.data = INACTIVE;
    e.oor  = 1'b1;
    for (int i = 0; i < OUT_W; i++) begin
      if (s == SEL_W'(i)) begin
        e.data[i] = ~INACTIVE[i];
        e.oor     = 1'b0;
      end
    end
    return e;
  endfunction

  // in_ready deliberately ignores out_ready so there is no comb path through the block.
  assign bus.in_ready = !rst && bus.en && (state != FULL);
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = out_valid_q && bus.out_ready;
  assign dec          = decode(bus.in_sel);
  assign inc          = accept && dec.oor;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = oreg.data;
  assign bus.out_oor   = oreg.oor;
  assign bus.oor_count = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      oreg        <= IDLE_ENTRY;
      skid        <= IDLE_ENTRY;
      cnt         <= '0;
    end else begin
      // A clear coinciding with an oor accept still records that accept.
      if (bus.clr_count) begin
        cnt <= inc ? CNT_W'(1) : '0;
      end else if (inc && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + CNT_W'(1);
      end

      case (state)
        EMPTY: begin
          if (accept) begin
            oreg        <= dec;
            state       <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            oreg <= dec;
          end else if (accept) begin
            skid  <= dec;
            state <= FULL;
          end else if (drain) begin
            // OREG keeps the drained entry; it is simply no longer valid.
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (drain) begin
            oreg  <= skid;
            state <= ONE;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_pipe.sv
// Bench for decoder_pipe: two configurations driven with identical stimulus.
// A: SEL_W=3 OUT_W=8 one-cold CNT_W=16.  B: SEL_W=3 OUT_W=5 one-hot CNT_W=2.
// Each DUT is compared every cycle against a queue-based model of the pipe.
module tb_decoder_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decoder_pipe_if #(.SEL_W(3), .OUT_W(8), .CNT_W(16)) bus_a ();
  decoder_pipe_if #(.SEL_W(3), .OUT_W(5), .CNT_W(2))  bus_b ();

  decoder_pipe #(.SEL_W(3), .OUT_W(8), .ACTIVE_LOW(1), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  decoder_pipe #(.SEL_W(3), .OUT_W(5), .ACTIVE_LOW(0), .CNT_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int checks = 0;
  int errors = 0;

  // Model configuration per DUT (index 0 = A, 1 = B).
  int out_w   [2] = '{8, 5};
  int act_low [2] = '{1, 0};
  int cnt_max [2] = '{65535, 3};

  // Pending entries, {oor, data}; front is what the output should show.
  logic [32:0] qa[$];
  logic [32:0] qb[$];
  logic [32:0] last [2];
  int          cnt  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] inactive(input int d);
    return (act_low[d] != 0) ? (32'hFFFF_FFFF >> (32 - out_w[d])) : 32'd0;
  endfunction

  function automatic logic [32:0] ref_decode(input int d, input int sel);
    if (sel < out_w[d]) return {1'b0, inactive(d) ^ (32'd1 << sel)};
    return {1'b1, inactive(d)};
  endfunction

  task automatic model_reset();
    qa.delete();
    qb.delete();
    for (int d = 0; d < 2; d++) begin
      last[d] = {1'b0, inactive(d)};
      cnt[d]  = 0;
    end
  endtask

  // One clock: drive inputs, compare both DUTs with the model, advance the model.
  task automatic step(input bit iv, input int sel, input bit ordy, input bit e,
                      input bit clr, input bit r);
    bit          acc [2];
    bit          drn [2];
    int          sz;
    logic [32:0] head;
    logic [31:0] o_ir, o_ov, o_dat, o_oor, o_cnt;
    logic [32:0] nw;
    logic [2:0]  s3;
    bit          exp_ir;
    string       nm;
    s3 = sel[2:0];
    rst = r;
    bus_a.in_valid = iv;   bus_b.in_valid = iv;
    bus_a.in_sel   = s3;   bus_b.in_sel   = s3;
    bus_a.out_ready = ordy; bus_b.out_ready = ordy;
    bus_a.en        = e;    bus_b.en        = e;
    bus_a.clr_count = clr;  bus_b.clr_count = clr;
    #1;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        nm = "A"; sz = qa.size(); head = (sz > 0) ? qa[0] : last[0];
        o_ir = 32'(bus_a.in_ready); o_ov = 32'(bus_a.out_valid);
        o_dat = 32'(bus_a.out_data); o_oor = 32'(bus_a.out_oor); o_cnt = 32'(bus_a.oor_count);
      end else begin
        nm = "B"; sz = qb.size(); head = (sz > 0) ? qb[0] : last[1];
        o_ir = 32'(bus_b.in_ready); o_ov = 32'(bus_b.out_valid);
        o_dat = 32'(bus_b.out_data); o_oor = 32'(bus_b.out_oor); o_cnt = 32'(bus_b.oor_count);
      end
      exp_ir = !r && e && (sz < 2);
      check({nm, ".in_ready"},  o_ir,  32'(exp_ir));
      check({nm, ".out_valid"}, o_ov,  32'(sz > 0));
      check({nm, ".out_data"},  o_dat, head[31:0]);
      check({nm, ".out_oor"},   o_oor, 32'(head[32]));
      check({nm, ".oor_count"}, o_cnt, 32'(cnt[d]));
      acc[d] = iv && exp_ir;
      drn[d] = (sz > 0) && ordy;
    end
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      for (int d = 0; d < 2; d++) begin
        nw = ref_decode(d, int'(s3));
        if (d == 0) begin
          if (drn[0]) last[0] = qa.pop_front();
          if (acc[0]) qa.push_back(nw);
        end else begin
          if (drn[1]) last[1] = qb.pop_front();
          if (acc[1]) qb.push_back(nw);
        end
        if (clr) cnt[d] = (acc[d] && nw[32]) ? 1 : 0;
        else if (acc[d] && nw[32] && cnt[d] < cnt_max[d]) cnt[d] = cnt[d] + 1;
      end
    end
    @(negedge clk);
  endtask

  logic [7:0] t1_exp [8];
  int         t4_exp [5];

  initial begin
    t1_exp = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    t4_exp = '{1, 2, 3, 3, 3};
    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_b.in_valid = 1'b0;
    bus_a.in_sel = '0;     bus_b.in_sel = '0;
    bus_a.out_ready = 1'b0; bus_b.out_ready = 1'b0;
    bus_a.en = 1'b1;       bus_b.en = 1'b1;
    bus_a.clr_count = 1'b0; bus_b.clr_count = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();

    // Back-to-back selects 0..7, one word per cycle.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, k, 1'b1, 1'b1, 1'b0, 1'b0);
      check("t1_data", 32'(bus_a.out_data), 32'(t1_exp[k]));
      check("t1_in_ready", 32'(bus_a.in_ready), 32'd1);
    end
    step(1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0);

    // One-hot, OUT_W=5: in-range and out-of-range decode.
    step(1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 4, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t2_sel4", 32'(bus_b.out_data), 32'h10);
    step(1'b1, 6, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t2_sel6_data", 32'(bus_b.out_data), 32'h00);
    check("t2_sel6_oor", 32'(bus_b.out_oor), 32'd1);
    check("t2_sel6_cnt", 32'(bus_b.oor_count), 32'd1);
    step(1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Backpressure: two entries held, third waits, then released in order.
    step(1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 5, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 6, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t3_hold_data", 32'(bus_a.out_data), 32'hF7);
    check("t3_full_ready", 32'(bus_a.in_ready), 32'd0);
    step(1'b1, 6, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t3_second", 32'(bus_a.out_data), 32'hDF);
    step(1'b1, 6, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t3_third", 32'(bus_a.out_data), 32'hBF);
    step(1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Saturating 2-bit counter, then clear together with an oor accept.
    step(1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 7, 1'b1, 1'b1, 1'b0, 1'b0);
      check("t4_cnt", 32'(bus_b.oor_count), 32'(t4_exp[k]));
    end
    step(1'b1, 6, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t4_clr_inc", 32'(bus_b.oor_count), 32'd1);
    step(1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0);

    // en=0 while FULL: both entries drain, nothing accepted until en returns.
    step(1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t5_ready_one", 32'(bus_a.in_ready), 32'd0);
    step(1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t5_drained", 32'(bus_a.out_valid), 32'd0);
    step(1'b1, 3, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_resume", 32'(bus_a.out_data), 32'hF7);
    step(1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset while FULL discards everything.
    step(1'b1, 7, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 6, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("t6_valid", 32'(bus_a.out_valid), 32'd0);
    check("t6_data", 32'(bus_a.out_data), 32'hFF);
    check("t6_cnt", 32'(bus_b.oor_count), 32'd0);
    check("t6_ready", 32'(bus_a.in_ready), 32'd0);
    step(1'b1, 0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 2) != 0), int'($urandom_range(0, 7)),
           ($urandom_range(0, 1) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
